// File: rtl/uart_tx_fifo_core_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM states,
// parity_mode encodings and a parity-enable helper.
package uart_tx_fifo_core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE2 = 2'b11;

  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_core_if.sv
// Host-side byte handshake: the producer asserts send_en with data_byte,
// and the transmitter takes the byte whenever send_ready is high.
interface uart_tx_fifo_core_if #(
  parameter int DATA_W = 8
);
  logic              send_en;
  logic [DATA_W-1:0] data_byte;
  logic              send_ready;

  modport master (output send_en, output data_byte, input send_ready);
  modport slave  (input send_en, input data_byte, output send_ready);
endinterface

// File: rtl/uart_tx_fifo_core_fifo.sv
// Single-clock FIFO with show-ahead read data; writes to a full FIFO and
// reads from an empty one are ignored.
module uart_tx_fifo_core_fifo
  import uart_tx_fifo_core_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  localparam int AW     = $clog2(DEPTH),
  localparam int CNT_W  = AW + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr && !full;
  assign do_rd   = rd && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_core.sv
// FIFO-fed UART transmitter with runtime baud divisor, optional parity and
// one or two stop bits; frames run back to back while the FIFO has data.
module uart_tx_fifo_core
  import uart_tx_fifo_core_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int DIV_W      = 16,
  parameter  int FIFO_DEPTH = 8,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  uart_tx_fifo_core_if.slave host,
  input  logic [DIV_W-1:0]   baud_div,
  input  logic [1:0]         parity_mode,
  input  logic               stop2,
  output logic               tx,
  output logic               send_done,
  output logic               uart_state,
  output logic [CNT_W-1:0]   fifo_cnt
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

  state_t            state;
  logic [DIV_W-1:0]  baud_cnt;
  logic [DIV_W-1:0]  cfg_div;
  logic [3:0]        bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] head;
  logic [1:0]        cfg_par;
  logic              cfg_stop2;
  logic              par_bit;
  logic              armed;
  logic              fifo_empty;
  logic              fifo_full;
  logic              tick;
  logic              last_stop;
  logic              launch;

  uart_tx_fifo_core_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr      (host.send_en),
    .wr_data (host.data_byte),
    .rd      (launch),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  assign host.send_ready = !fifo_full;
  assign tick      = (baud_cnt == cfg_div);
  assign last_stop = (state == ST_STOP) && tick && (!cfg_stop2 || bit_cnt[0]);
  // An idle launch waits one cycle after the FIFO turns non-empty, which
  // fixes write-to-start-bit latency at two edges.
  assign launch    = !fifo_empty && (((state == ST_IDLE) && armed) || last_stop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      cfg_div    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      cfg_par    <= PAR_NONE;
      cfg_stop2  <= 1'b0;
      par_bit    <= 1'b0;
      armed      <= 1'b0;
      tx         <= 1'b1;
      send_done  <= 1'b0;
      uart_state <= 1'b0;
    end else begin
      send_done <= 1'b0;
      armed     <= !fifo_empty;
      if (state != ST_IDLE) baud_cnt <= tick ? '0 : baud_cnt + DIV_W'(1);
      case (state)
        ST_START: if (tick) begin
          state     <= ST_DATA;
          tx        <= shift_reg[0];
          shift_reg <= shift_reg >> 1;
          bit_cnt   <= '0;
        end
        ST_DATA: if (tick) begin
          if (bit_cnt == LAST_BIT) begin
            if (parity_on(cfg_par)) begin
              state <= ST_PARITY;
              tx    <= par_bit;
            end else begin
              state   <= ST_STOP;
              tx      <= 1'b1;
              bit_cnt <= '0;
            end
          end else begin
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + 4'd1;
          end
        end
        ST_PARITY: if (tick) begin
          state   <= ST_STOP;
          tx      <= 1'b1;
          bit_cnt <= '0;
        end
        ST_STOP: if (tick) begin
          if (last_stop) begin
            send_done  <= 1'b1;
            state      <= ST_IDLE;
            uart_state <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        default: ;
      endcase
      // Frame start overrides the end-of-frame return to idle for zero-gap bursts.
      if (launch) begin
        state      <= ST_START;
        tx         <= 1'b0;
        uart_state <= 1'b1;
        baud_cnt   <= '0;
        shift_reg  <= head;
        cfg_div    <= baud_div;
        cfg_par    <= parity_mode;
        cfg_stop2  <= stop2;
        par_bit    <= (^head) ^ (parity_mode == PAR_ODD);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_core.sv
// Directed bench for uart_tx_fifo_core: frame timing, parity modes, FIFO
// burst/full, minimum divisor, mid-frame reconfiguration and reset abort.
module tb_uart_tx_fifo_core;

  logic        clk;
  logic        reset_n;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic        tx;
  logic        send_done;
  logic        uart_state;
  logic [3:0]  fifo_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [1:0]  t2_mode  [3] = '{2'b10, 2'b01, 2'b11};
  logic [11:0] t2_frame [3] = '{12'h60E, 12'h40E, 12'h20E};
  int          t2_bits  [3] = '{11, 11, 10};

  uart_tx_fifo_core_if #(.DATA_W(8)) bus ();

  uart_tx_fifo_core #(
    .DATA_W     (8),
    .DIV_W      (16),
    .FIFO_DEPTH (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .host        (bus),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .tx          (tx),
    .send_done   (send_done),
    .uart_state  (uart_state),
    .fifo_cnt    (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] value);
    bus.send_en   = 1'b1;
    bus.data_byte = value;
    step();
    bus.send_en   = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, " tx"}, tx, 1'b1);
    check_output({tag, " send_done"}, send_done, 1'b0);
    check_output({tag, " uart_state"}, uart_state, 1'b0);
    check_output({tag, " fifo_cnt"}, fifo_cnt, 4'd0);
    check_output({tag, " send_ready"}, bus.send_ready, 1'b1);
  endtask

  task automatic wait_start(input string tag, input int limit);
    int n = 0;
    while (tx !== 1'b0 && n < limit) begin
      step();
      n++;
    end
    check_output({tag, " start seen"}, tx, 1'b0);
  endtask

  // Entered on the first cycle of the start bit; leaves just after the edge
  // that closes the last stop bit, where send_done must be high.
  task automatic expect_frame(input string tag, input logic [11:0] bits, input int nbits, input int period);
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < period; c++) begin
        check_output($sformatf("%s bit%0d cyc%0d tx", tag, i, c), tx, bits[i]);
        if (c == 0 && i > 0)
          check_output($sformatf("%s bit%0d send_done", tag, i), send_done, 1'b0);
        step();
      end
    end
    check_output({tag, " send_done pulse"}, send_done, 1'b1);
  endtask

  initial begin
    bus.send_en   = 1'b0;
    bus.data_byte = 8'h00;
    reset_n       = 1'b0;
    baud_div      = 16'd3;
    parity_mode   = 2'b00;
    stop2         = 1'b0;

    repeat (3) step();
    check_idle("reset");
    #3 reset_n = 1'b1;
    step();
    check_idle("post reset");

    // 8N1 at four clocks per bit with exact write-to-start latency
    apply_stimulus(8'hA5);
    check_output("t1 cnt after write", fifo_cnt, 4'd1);
    check_output("t1 tx edge N", tx, 1'b1);
    step();
    check_output("t1 tx edge N+1", tx, 1'b1);
    check_output("t1 state edge N+1", uart_state, 1'b0);
    step();
    check_output("t1 state edge N+2", uart_state, 1'b1);
    check_output("t1 cnt after pop", fifo_cnt, 4'd0);
    expect_frame("t1", 12'h34A, 10, 4);
    check_output("t1 end tx", tx, 1'b1);
    check_output("t1 end state", uart_state, 1'b0);

    // Even, odd and the second no-parity encoding on 0x07
    baud_div = 16'd1;
    for (int k = 0; k < 3; k++) begin
      parity_mode = t2_mode[k];
      apply_stimulus(8'h07);
      wait_start($sformatf("t2 mode%0d", k), 10);
      expect_frame($sformatf("t2 mode%0d", k), t2_frame[k], t2_bits[k], 2);
    end
    parity_mode = 2'b00;

    // Ten writes from idle: nine accepted, last dropped, nine gapless frames
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          if (i == 8) begin
            check_output("t3 cnt before 9th", fifo_cnt, 4'd7);
            check_output("t3 ready before 9th", bus.send_ready, 1'b1);
          end
          if (i == 9) begin
            check_output("t3 cnt before 10th", fifo_cnt, 4'd8);
            check_output("t3 ready before 10th", bus.send_ready, 1'b0);
          end
          apply_stimulus(8'h30 + 8'(i));
        end
        check_output("t3 cnt after drop", fifo_cnt, 4'd8);
      end
      begin
        wait_start("t3", 10);
        for (int f = 0; f < 9; f++)
          expect_frame($sformatf("t3 f%0d", f), {3'b001, 8'h30 + 8'(f), 1'b0}, 10, 2);
      end
    join
    check_output("t3 end state", uart_state, 1'b0);
    check_output("t3 end cnt", fifo_cnt, 4'd0);
    repeat (6) step();
    check_output("t3 dropped not sent tx", tx, 1'b1);
    check_output("t3 dropped not sent state", uart_state, 1'b0);

    // One clock per bit, even parity, two stop bits
    baud_div    = 16'd0;
    stop2       = 1'b1;
    parity_mode = 2'b10;
    apply_stimulus(8'h5A);
    wait_start("t4", 10);
    expect_frame("t4", 12'hCB4, 12, 1);
    stop2       = 1'b0;
    parity_mode = 2'b00;

    // Config changed during frame 1 data bits only affects frame 2
    baud_div = 16'd3;
    apply_stimulus(8'h3C);
    apply_stimulus(8'hC3);
    wait_start("t5", 10);
    fork
      begin
        repeat (8) step();
        baud_div = 16'd7;
        stop2    = 1'b1;
      end
      begin
        expect_frame("t5 f1", 12'h278, 10, 4);
        expect_frame("t5 f2", 12'h786, 11, 8);
      end
    join
    check_output("t5 end tx", tx, 1'b1);
    baud_div = 16'd3;
    stop2    = 1'b0;

    // Reset lands during data bit 3 of the first of four queued bytes
    apply_stimulus(8'h11);
    apply_stimulus(8'h22);
    apply_stimulus(8'h33);
    apply_stimulus(8'h44);
    check_output("t6 cnt queued", fifo_cnt, 4'd3);
    repeat (16) step();
    check_output("t6 busy before reset", uart_state, 1'b1);
    check_output("t6 data bit3", tx, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check_idle("t6 async");
    step();
    step();
    check_idle("t6 held");
    #3 reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      check_output($sformatf("t6 post cyc%0d tx", c), tx, 1'b1);
      check_output($sformatf("t6 post cyc%0d send_done", c), send_done, 1'b0);
      check_output($sformatf("t6 post cyc%0d state", c), uart_state, 1'b0);
    end
    check_output("t6 post cnt", fifo_cnt, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no completion, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
